// File: rtl/addr_sequencer.sv
// -----------------------------------------------------------------------------
// addr_sequencer
//
// Generates a read address that moves between a programmable lower and upper
// bound (both inclusive). Four modes are supported: up with wrap, down with
// wrap, ping-pong, and one-shot up. An internal rate divider lets the address
// advance only every div+1 enabled cycles. The block is intended to drive the
// read port of a RAM or ROM for display or playback.
//
// Parameters
//   ADDR_W      width of the address and of the bounds
//   DIV_W       width of the rate-divider count
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   en          advance enable; low freezes both the address and the divider
//   restart     synchronous reload to the start of the sequence
//   mode        00 up-wrap, 01 down-wrap, 10 ping-pong, 11 one-shot up
//   lo, hi      lower / upper address bound (inclusive)
//   div         address advances every div+1 enabled cycles
//   addr        current address (registered)
//   dir         0 = moving up, 1 = moving down (registered)
//   wrap        one-cycle pulse on bound turnaround or wrap (registered)
//   done        one-shot sequence finished, level (registered)
//   bad_bounds  combinational, high while lo > hi
// -----------------------------------------------------------------------------
module addr_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  input  logic [DIV_W-1:0]  div,
  output logic [ADDR_W-1:0] addr,
  output logic              dir,
  output logic              wrap,
  output logic              done,
  output logic              bad_bounds
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DIV_W-1:0]  TCNT_ONE = DIV_W'(1);

  mode_e             mode_s;
  logic              tick;
  logic              in_range;
  logic              at_lo;
  logic              at_hi;

  logic [DIV_W-1:0]  tcnt_q,  tcnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              dir_q,   dir_d;
  logic              wrap_q,  wrap_d;
  logic              done_q,  done_d;

  assign mode_s     = mode_e'(mode);
  assign bad_bounds = (lo > hi);
  assign in_range   = (addr_q >= lo) && (addr_q <= hi);
  assign at_lo      = (addr_q == lo);
  assign at_hi      = (addr_q == hi);

  // Rate divider. Restart clears the count and suppresses the tick on that
  // edge, so a restart while enabled costs exactly one cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    tick   = 1'b0;
    tcnt_d = tcnt_q;
    if (restart) begin
      tcnt_d = '0;
    end else if (en) begin
      if (tcnt_q >= div) begin
        tcnt_d = '0;
        tick   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TCNT_ONE;
      end
    end
  end

  // Address / direction / done next-state. wrap defaults low so it can only
  // ever be a single-cycle pulse.
  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    done_d = done_q;
    wrap_d = 1'b0;

    if (restart) begin
      addr_d = (mode_s == MODE_DOWN) ? hi : lo;
      dir_d  = (mode_s == MODE_DOWN);
      done_d = 1'b0;
    end else if (tick && !bad_bounds) begin
      unique case (mode_s)
        MODE_UP: begin
          dir_d = 1'b0;
          if (!in_range) begin
            addr_d = lo;
          end else if (at_hi) begin
            // Comparing against hi (not relying on overflow) keeps hi = max
            // wrapping back to lo.
            addr_d = lo;
            wrap_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end

        MODE_DOWN: begin
          dir_d = 1'b1;
          if (!in_range) begin
            addr_d = hi;
          end else if (at_lo) begin
            addr_d = hi;
            wrap_d = 1'b1;
          end else begin
            addr_d = addr_q - ADDR_ONE;
          end
        end

        MODE_PING: begin
          if (!in_range) begin
            // Re-enter from the bound we are heading away from.
            addr_d = dir_q ? hi : lo;
          end else if (lo == hi) begin
            // Degenerate window: stay put but keep turning around.
            addr_d = lo;
            dir_d  = ~dir_q;
            wrap_d = 1'b1;
          end else if (!dir_q) begin
            if (at_hi) begin
              addr_d = hi - ADDR_ONE;
              dir_d  = 1'b1;
              wrap_d = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end else begin
            if (at_lo) begin
              addr_d = lo + ADDR_ONE;
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end else begin
              addr_d = addr_q - ADDR_ONE;
            end
          end
        end

        MODE_ONESHOT: begin
          // Once finished, the sequence is frozen until restart or reset.
          if (!done_q) begin
            dir_d = 1'b0;
            if (!in_range) begin
              addr_d = lo;
            end else if (at_hi) begin
              done_d = 1'b1;
              wrap_d = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      tcnt_q <= '0;
      addr_q <= '0;
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      addr_q <= addr_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign addr = addr_q;
  assign dir  = dir_q;
  assign wrap = wrap_q;
  assign done = done_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_addr_sequencer
//
// Directed stimulus for addr_sequencer. Each stimulus step drives the inputs
// for one clock edge and pushes the hand-derived post-edge outputs into a
// scoreboard queue; a separate monitor pops one entry per cycle on the falling
// edge and compares it with what the DUT presents.
// -----------------------------------------------------------------------------
module tb_addr_sequencer;

  localparam int ADDR_W = 5;
  localparam int DIV_W  = 8;

  typedef struct {
    string             tag;
    logic [ADDR_W-1:0] addr;
    logic              dir;
    logic              wrap;
    logic              done;
    logic              bad;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic              restart = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [ADDR_W-1:0] lo = '0;
  logic [ADDR_W-1:0] hi = '0;
  logic [DIV_W-1:0]  div = '0;
  logic [ADDR_W-1:0] addr;
  logic              dir;
  logic              wrap;
  logic              done;
  logic              bad_bounds;

  // Configuration shadows, applied to the DUT at the next step.
  logic [1:0]        c_mode = 2'b00;
  logic [ADDR_W-1:0] c_lo = '0;
  logic [ADDR_W-1:0] c_hi = '0;
  logic [DIV_W-1:0]  c_div = '0;
  string             cur_tag = "init";

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  addr_sequencer #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .restart    (restart),
    .mode       (mode),
    .lo         (lo),
    .hi         (hi),
    .div        (div),
    .addr       (addr),
    .dir        (dir),
    .wrap       (wrap),
    .done       (done),
    .bad_bounds (bad_bounds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] m, input int l, input int h, input int d);
    c_mode = m;
    c_lo   = ADDR_W'(l);
    c_hi   = ADDR_W'(h);
    c_div  = DIV_W'(d);
  endtask

  // Drive one edge worth of inputs and queue the outputs expected after it.
  task automatic step(input logic r, input logic e, input logic rs,
                      input int ea, input logic ed, input logic ew,
                      input logic edn, input logic eb);
    exp_t x;
    @(negedge clk);
    #1;
    reset   = r;
    en      = e;
    restart = rs;
    mode    = c_mode;
    lo      = c_lo;
    hi      = c_hi;
    div     = c_div;
    x.tag   = cur_tag;
    x.addr  = ADDR_W'(ea);
    x.dir   = ed;
    x.wrap  = ew;
    x.done  = edn;
    x.bad   = eb;
    sb_q.push_back(x);
  endtask

  // Monitor: one scoreboard entry per falling edge, i.e. after the edge the
  // entry describes and before the next stimulus is applied.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      check({x.tag, ".addr"}, 32'(addr),       32'(x.addr));
      check({x.tag, ".dir"},  32'(dir),        32'(x.dir));
      check({x.tag, ".wrap"}, 32'(wrap),       32'(x.wrap));
      check({x.tag, ".done"}, 32'(done),       32'(x.done));
      check({x.tag, ".bad"},  32'(bad_bounds), 32'(x.bad));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    logic w;

    // Full-range up count with wrap at hi = 31.
    cur_tag = "up_full";
    cfg(2'b00, 0, 31, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 33; i++)
      step(0, 1, 0, i % 32, 0, (i == 32), 0, 0);

    // Up within 4..7, advancing every third cycle.
    cur_tag = "up_div2";
    cfg(2'b00, 4, 7, 2);
    step(0, 1, 1, 4, 0, 0, 0, 0);
    cur = 4;
    for (int k = 1; k <= 12; k++) begin
      w = 1'b0;
      if (k % 3 == 0) begin
        w   = (cur == 7);
        cur = (cur == 7) ? 4 : cur + 1;
      end
      step(0, 1, 0, cur, 0, w, 0, 0);
    end

    // Ping-pong 2..5.
    cur_tag = "ping";
    cfg(2'b10, 2, 5, 0);
    step(0, 1, 1, 2, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0, 0, 0, 0);
    step(0, 1, 0, 4, 0, 0, 0, 0);
    step(0, 1, 0, 5, 0, 0, 0, 0);
    step(0, 1, 0, 4, 1, 1, 0, 0);
    step(0, 1, 0, 3, 1, 0, 0, 0);
    step(0, 1, 0, 2, 1, 0, 0, 0);
    step(0, 1, 0, 3, 0, 1, 0, 0);
    step(0, 1, 0, 4, 0, 0, 0, 0);

    // One-shot 0..3, then leaving one-shot keeps done.
    cur_tag = "oneshot";
    cfg(2'b11, 0, 3, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0, 1, 1, 0);
    step(0, 1, 0, 3, 0, 0, 1, 0);
    step(0, 1, 0, 3, 0, 0, 1, 0);
    cur_tag = "oneshot_leave";
    cfg(2'b00, 0, 3, 0);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    cur_tag = "oneshot_restart";
    cfg(2'b11, 0, 3, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);

    // Enable gating with div = 3: the count resumes where it stopped.
    cur_tag = "en_gate";
    cfg(2'b00, 0, 31, 3);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 2, 0, 0, 0, 0);

    // Reset while done and wrap are both high.
    cur_tag = "mid_reset";
    cfg(2'b11, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);

    // Upper bound pulled below the current address.
    cur_tag = "hi_shrink";
    cfg(2'b00, 20, 31, 0);
    step(0, 1, 1, 20, 0, 0, 0, 0);
    cfg(2'b00, 0, 10, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);

    // Inverted bounds: address holds, flag raised.
    cur_tag = "bad_bounds";
    cfg(2'b00, 9, 3, 0);
    step(0, 1, 0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 0, 0, 1);

    // Full-range down count with wrap at lo = 0.
    cur_tag = "down_full";
    cfg(2'b01, 0, 31, 0);
    step(0, 1, 1, 31, 1, 0, 0, 0);
    for (int i = 1; i <= 32; i++)
      step(0, 1, 0, (i == 32) ? 31 : 31 - i, 1, (i == 32), 0, 0);

    // Ping-pong with a single-address window.
    cur_tag = "ping_single";
    cfg(2'b10, 6, 6, 0);
    step(0, 1, 1, 6, 0, 0, 0, 0);
    step(0, 1, 0, 6, 1, 1, 0, 0);
    step(0, 1, 0, 6, 0, 1, 0, 0);

    // Let the monitor drain the scoreboard, bounded.
    cur_tag = "drain";
    for (int n = 0; n < 4 && sb_q.size() > 0; n++)
      @(negedge clk);
    #1;
    check("drain.queue_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
